// File: rtl/dispatch_queue.sv
// Dispatch queue between rename and the ROB/RS issue side, with CDB wakeup of buffered source operands.
// Optional same-cycle bypass of an incoming packet into an empty queue: define DISPATCH_BYPASS_EN.

package ooop_types;

    localparam int N_PHYS_REGS = 64;
    localparam int ROB_DEPTH   = 32;
    localparam int PREG_W      = $clog2(N_PHYS_REGS);
    localparam int ROB_W       = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic              valid;
        logic [3:0]        uop;
        logic [ROB_W-1:0]  rob_tag;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] prs1;
        logic              prs1_ready;
        logic [PREG_W-1:0] prs2;
        logic              prs2_ready;
        logic              is_load;
        logic              is_store;
        logic              is_branch;
        logic              is_jump;
    } rename_pkt_t;

    typedef enum logic [1:0] {
        RS_ALU = 2'd0,
        RS_BRU = 2'd1,
        RS_LSU = 2'd2
    } rs_class_e;

endpackage

module dispatch_queue #(
    parameter int DEPTH       = 4,
    parameter int N_PHYS_REGS = ooop_types::N_PHYS_REGS,
    parameter int ROB_DEPTH   = ooop_types::ROB_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           recover_i,
    input  logic                           valid_in,
    output logic                           ready_out,
    input  ooop_types::rename_pkt_t        pkt_in,
    input  logic                           cdb_valid_i,
    input  logic [$clog2(N_PHYS_REGS)-1:0] cdb_preg_i,
    output logic                           rob_valid_o,
    input  logic                           rob_ready_i,
    output logic                           alu_valid_o,
    input  logic                           alu_ready_i,
    output logic                           bru_valid_o,
    input  logic                           bru_ready_i,
    output logic                           lsu_valid_o,
    input  logic                           lsu_ready_i,
    output ooop_types::rename_pkt_t        pkt_out,
    output logic [$clog2(DEPTH):0]         count_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PREG_W = $clog2(N_PHYS_REGS);

    typedef ooop_types::rename_pkt_t pkt_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dispatch_queue: DEPTH must be a power of 2 and at least 2");
    end
    // The packet layout is fixed by the package, so the register/ROB sizes must agree with it.
    if (PREG_W != ooop_types::PREG_W) begin : g_bad_preg
        $error("dispatch_queue: N_PHYS_REGS does not match ooop_types::PREG_W");
    end
    if ($clog2(ROB_DEPTH) != ooop_types::ROB_W) begin : g_bad_rob
        $error("dispatch_queue: ROB_DEPTH does not match ooop_types::ROB_W");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic pkt_t snoop(input pkt_t p, input logic cv, input logic [PREG_W-1:0] cp);
        pkt_t r;
        r = p;
        if (p.prs1 == '0 || (cv && p.prs1 == cp)) r.prs1_ready = 1'b1;
        if (p.prs2 == '0 || (cv && p.prs2 == cp)) r.prs2_ready = 1'b1;
        return r;
    endfunction

    function automatic ooop_types::rs_class_e classify(input pkt_t p);
        if (p.is_load || p.is_store)  return ooop_types::RS_LSU;
        if (p.is_branch || p.is_jump) return ooop_types::RS_BRU;
        return ooop_types::RS_ALU;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pkt_t             mem [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic                  kill;
    logic                  head_valid;
    logic                  bypass;
    logic                  out_valid;
    logic                  sel_ready;
    logic                  deq;
    logic                  pop;
    logic                  enq;
    pkt_t                  out_pkt;
    pkt_t                  in_snooped;
    ooop_types::rs_class_e out_cls;

    assign kill       = flush_i | recover_i;
    assign head_valid = entry_valid[head];
    assign ready_out  = (count < CNT_W'(DEPTH));
    assign count_o    = count;
    assign in_snooped = snoop(pkt_in, cdb_valid_i, cdb_preg_i);

`ifdef DISPATCH_BYPASS_EN
    // An empty queue lets the incoming packet be offered downstream in the same cycle.
    assign bypass = !head_valid && valid_in;
`else
    assign bypass = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Head selection, routing and the all-or-nothing dispatch handshake
    // ------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        out_pkt = '0;
        if (head_valid) begin
            out_pkt       = snoop(mem[head], cdb_valid_i, cdb_preg_i);
            out_pkt.valid = 1'b1;
        end else if (bypass) begin
            out_pkt       = in_snooped;
            out_pkt.valid = 1'b1;
        end
    end

    assign pkt_out   = out_pkt;
    assign out_valid = head_valid | bypass;
    assign out_cls   = classify(out_pkt);

    always_comb begin
        sel_ready = 1'b0;
        case (out_cls)
            ooop_types::RS_ALU: sel_ready = alu_ready_i;
            ooop_types::RS_BRU: sel_ready = bru_ready_i;
            ooop_types::RS_LSU: sel_ready = lsu_ready_i;
            default:            sel_ready = 1'b0;
        endcase
    end

    // ROB and the chosen RS see the same beat; a flush/recover cycle dispatches nothing.
    assign deq         = out_valid && rob_ready_i && sel_ready && !kill;
    assign rob_valid_o = deq;
    assign alu_valid_o = deq && (out_cls == ooop_types::RS_ALU);
    assign bru_valid_o = deq && (out_cls == ooop_types::RS_BRU);
    assign lsu_valid_o = deq && (out_cls == ooop_types::RS_LSU);

    assign pop = deq && head_valid;
    assign enq = valid_in && ready_out && !kill && !(bypass && deq);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (enq) begin
                entry_valid[tail] <= 1'b1;
                tail              <= tail + PTR_W'(1);
            end
            if (pop) begin
                entry_valid[head] <= 1'b0;
                head              <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Payload storage with CDB wakeup
    // ------------------------------------------------------------------
    // NOTE: the payload array is not reset; entry_valid alone decides whether a slot is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && tail == PTR_W'(i)) begin
                mem[i] <= in_snooped;
            end else if (entry_valid[i]) begin
                mem[i] <= snoop(mem[i], cdb_valid_i, cdb_preg_i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));

    a_one_rs: assert property (@(posedge clk) disable iff (rst)
        $onehot0({alu_valid_o, bru_valid_o, lsu_valid_o}));

    a_rob_with_rs: assert property (@(posedge clk) disable iff (rst)
        rob_valid_o == (alu_valid_o | bru_valid_o | lsu_valid_o));

    a_no_dispatch_on_kill: assert property (@(posedge clk) disable iff (rst)
        kill |-> !rob_valid_o);

    a_count_matches_valid: assert property (@(posedge clk) disable iff (rst)
        (count == '0) == (entry_valid == '0));

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: directed stimulus pushes expected dispatches, a negedge monitor checks them.
// Same-cycle latency expectations follow DISPATCH_BYPASS_EN when it is defined.

module tb_dispatch_queue;
    import ooop_types::*;

    localparam int DEPTH = 4;
`ifdef DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int C_ALU = 0;
    localparam int C_BR  = 1;
    localparam int C_JMP = 2;
    localparam int C_LD  = 3;
    localparam int C_ST  = 4;

    logic               clk;
    logic               rst;
    logic               flush_i;
    logic               recover_i;
    logic               valid_in;
    logic               ready_out;
    rename_pkt_t        pkt_in;
    logic               cdb_valid_i;
    logic [PREG_W-1:0]  cdb_preg_i;
    logic               rob_valid_o;
    logic               rob_ready_i;
    logic               alu_valid_o;
    logic               alu_ready_i;
    logic               bru_valid_o;
    logic               bru_ready_i;
    logic               lsu_valid_o;
    logic               lsu_ready_i;
    rename_pkt_t        pkt_out;
    logic [2:0]         count_o;

    dispatch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .recover_i   (recover_i),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .pkt_in      (pkt_in),
        .cdb_valid_i (cdb_valid_i),
        .cdb_preg_i  (cdb_preg_i),
        .rob_valid_o (rob_valid_o),
        .rob_ready_i (rob_ready_i),
        .alu_valid_o (alu_valid_o),
        .alu_ready_i (alu_ready_i),
        .bru_valid_o (bru_valid_o),
        .bru_ready_i (bru_ready_i),
        .lsu_valid_o (lsu_valid_o),
        .lsu_ready_i (lsu_ready_i),
        .pkt_out     (pkt_out),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        rename_pkt_t pkt;
        logic [2:0]  rs;   // {lsu, bru, alu}
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rename_pkt_t mk(input int cls, input int prd, input int tag,
                                       input int prs1, input bit r1, input int prs2, input bit r2);
        rename_pkt_t p;
        p            = '0;
        p.valid      = 1'b1;
        p.uop        = 4'(cls + 1);
        p.rob_tag    = ROB_W'(tag);
        p.prd        = PREG_W'(prd);
        p.prs1       = PREG_W'(prs1);
        p.prs1_ready = r1;
        p.prs2       = PREG_W'(prs2);
        p.prs2_ready = r2;
        p.is_branch  = (cls == C_BR);
        p.is_jump    = (cls == C_JMP);
        p.is_load    = (cls == C_LD);
        p.is_store   = (cls == C_ST);
        return p;
    endfunction

    function automatic logic [2:0] rs_of(input int cls);
        if (cls == C_ALU)               return 3'b001;
        if (cls == C_BR || cls == C_JMP) return 3'b010;
        return 3'b100;
    endfunction

    task automatic expect_dispatch(input rename_pkt_t p, input int cls, input bit er1, input bit er2);
        exp_t e;
        e.pkt            = p;
        e.pkt.valid      = 1'b1;
        e.pkt.prs1_ready = er1;
        e.pkt.prs2_ready = er2;
        e.rs             = rs_of(cls);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present p and hold it until an edge where ready_out was high.
    task automatic enq_wait(input rename_pkt_t p, input string name);
        int budget;
        valid_in = 1'b1;
        pkt_in   = p;
        budget   = 40;
        @(negedge clk);
        while (!ready_out && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        if (budget == 0) check({name, "_accept_timeout"}, 64'(ready_out), 64'd1);
        step();
        valid_in = 1'b0;
        pkt_in   = '0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 60;
        while ((count_o != 0 || sb.size() != 0) && budget > 0) begin
            budget--;
            step();
        end
        @(negedge clk);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_count_zero"}, 64'(count_o), 64'd0);
    endtask

    // Monitor: every beat the DUT dispatches is matched against the oldest expected one.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [2:0] rs;
        if (!rst) begin
            rs = {lsu_valid_o, bru_valid_o, alu_valid_o};
            if (rob_valid_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_dispatch: got pkt %0h rs %b expected no dispatch", pkt_out, rs);
                end else begin
                    e = sb.pop_front();
                    check("dispatch_pkt", 64'(pkt_out), 64'(e.pkt));
                    check("dispatch_route", 64'(rs), 64'(e.rs));
                end
            end else if (rs != 3'b000) begin
                n_cmp++;
                n_err++;
                $display("FAIL rs_without_rob: got rs %b expected 000", rs);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rename_pkt_t p;
        rename_pkt_t b [5];
        int          cls_seq [10];

        rst         = 1'b1;
        flush_i     = 1'b0;
        recover_i   = 1'b0;
        valid_in    = 1'b0;
        pkt_in      = '0;
        cdb_valid_i = 1'b0;
        cdb_preg_i  = '0;
        rob_ready_i = 1'b1;
        alu_ready_i = 1'b1;
        bru_ready_i = 1'b1;
        lsu_ready_i = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // ---------------- Reset state ----------------
        @(negedge clk);
        check("reset_count", 64'(count_o), 64'd0);
        check("reset_ready_out", 64'(ready_out), 64'd1);
        check("reset_valids", 64'({rob_valid_o, alu_valid_o, bru_valid_o, lsu_valid_o}), 64'd0);
        check("reset_pkt_out", 64'(pkt_out), 64'd0);
        step();

        // ---------------- Single ALU packet latency ----------------
        p = mk(C_ALU, 5, 3, 2, 1'b1, 3, 1'b0);
        expect_dispatch(p, C_ALU, 1'b1, 1'b0);
        valid_in = 1'b1;
        pkt_in   = p;
        @(negedge clk);
        check("t1_same_cycle", 64'({rob_valid_o, alu_valid_o}), BYP ? 64'd3 : 64'd0);
        step();
        valid_in = 1'b0;
        pkt_in   = '0;
        @(negedge clk);
        check("t1_next_cycle", 64'({rob_valid_o, alu_valid_o}), BYP ? 64'd0 : 64'd3);
        step();
        @(negedge clk);
        check("t1_count_back_to_zero", 64'(count_o), 64'd0);
        step();

        // ---------------- Fill to DEPTH with ROB stalled ----------------
        rob_ready_i = 1'b0;
        b[0] = mk(C_ALU, 10, 1, 0, 1'b0, 4, 1'b1);
        b[1] = mk(C_BR,  11, 2, 5, 1'b0, 6, 1'b0);
        b[2] = mk(C_ST,  12, 3, 7, 1'b1, 8, 1'b1);
        b[3] = mk(C_JMP, 13, 4, 9, 1'b1, 0, 1'b0);
        b[4] = mk(C_LD,  14, 5, 1, 1'b1, 2, 1'b1);
        expect_dispatch(b[0], C_ALU, 1'b1, 1'b1);
        expect_dispatch(b[1], C_BR,  1'b0, 1'b0);
        expect_dispatch(b[2], C_ST,  1'b1, 1'b1);
        expect_dispatch(b[3], C_JMP, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            valid_in = 1'b1;
            pkt_in   = b[k];
            step();
        end
        pkt_in = b[4];
        @(negedge clk);
        check("t2_full_count", 64'(count_o), 64'd4);
        check("t2_full_ready_out", 64'(ready_out), 64'd0);
        step();
        @(negedge clk);
        check("t2_fifth_rejected", 64'(count_o), 64'd4);
        step();
        valid_in    = 1'b0;
        pkt_in      = '0;
        rob_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_drain_rob_valid", 64'(rob_valid_o), 64'd1);
            check("t2_drain_count", 64'(count_o), 64'(4 - k));
            step();
        end
        drain("t2");

        // ---------------- CDB wakeup ----------------
        rob_ready_i = 1'b0;
        p = mk(C_ALU, 8, 10, 17, 1'b0, 20, 1'b0);
        expect_dispatch(p, C_ALU, 1'b1, 1'b0);
        valid_in = 1'b1;
        pkt_in   = p;
        step();
        valid_in = 1'b0;
        pkt_in   = '0;
        @(negedge clk);
        check("t3_prs1_not_ready", 64'(pkt_out.prs1_ready), 64'd0);
        step();
        cdb_valid_i = 1'b1;
        cdb_preg_i  = PREG_W'(17);
        p = mk(C_BR, 9, 11, 17, 1'b0, 0, 1'b0);
        expect_dispatch(p, C_BR, 1'b1, 1'b1);
        valid_in = 1'b1;
        pkt_in   = p;
        @(negedge clk);
        check("t3_cdb_comb_prs1", 64'(pkt_out.prs1_ready), 64'd1);
        check("t3_cdb_comb_prs2", 64'(pkt_out.prs2_ready), 64'd0);
        step();
        cdb_valid_i = 1'b0;
        cdb_preg_i  = '0;
        valid_in    = 1'b0;
        pkt_in      = '0;
        @(negedge clk);
        check("t3_prs1_stored", 64'(pkt_out.prs1_ready), 64'd1);
        check("t3_count", 64'(count_o), 64'd2);
        step();
        rob_ready_i = 1'b1;
        drain("t3");

        // ---------------- In-order block on a busy LSU ----------------
        lsu_ready_i = 1'b0;
        p = mk(C_LD, 21, 12, 3, 1'b1, 4, 1'b1);
        expect_dispatch(p, C_LD, 1'b1, 1'b1);
        valid_in = 1'b1;
        pkt_in   = p;
        step();
        p = mk(C_ALU, 22, 13, 5, 1'b1, 6, 1'b0);
        expect_dispatch(p, C_ALU, 1'b1, 1'b0);
        pkt_in = p;
        step();
        valid_in = 1'b0;
        pkt_in   = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t4_blocked_valids", 64'({rob_valid_o, alu_valid_o, bru_valid_o, lsu_valid_o}), 64'd0);
            check("t4_head_is_load", 64'(pkt_out.is_load), 64'd1);
            check("t4_count", 64'(count_o), 64'd2);
            step();
        end
        lsu_ready_i = 1'b1;
        drain("t4");

        // ---------------- Recover with 3 entries and a coincident enqueue ----------------
        rob_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_in = 1'b1;
            pkt_in   = mk(C_ALU, 30 + k, 20 + k, 1, 1'b1, 2, 1'b1);
            step();
        end
        valid_in = 1'b0;
        @(negedge clk);
        check("t5_pre_recover_count", 64'(count_o), 64'd3);
        step();
        recover_i   = 1'b1;
        valid_in    = 1'b1;
        pkt_in      = mk(C_BR, 40, 25, 1, 1'b1, 2, 1'b1);
        rob_ready_i = 1'b1;
        @(negedge clk);
        check("t5_recover_no_dispatch", 64'({rob_valid_o, alu_valid_o, bru_valid_o, lsu_valid_o}), 64'd0);
        check("t5_recover_head_visible", 64'(pkt_out.valid), 64'd1);
        step();
        recover_i = 1'b0;
        valid_in  = 1'b0;
        pkt_in    = '0;
        @(negedge clk);
        check("t5_post_recover_count", 64'(count_o), 64'd0);
        check("t5_post_recover_ready", 64'(ready_out), 64'd1);
        check("t5_post_recover_pkt_out", 64'(pkt_out), 64'd0);
        step();

        // ---------------- Flush behaves the same ----------------
        rob_ready_i = 1'b0;
        valid_in    = 1'b1;
        pkt_in      = mk(C_ST, 41, 26, 1, 1'b1, 2, 1'b1);
        step();
        flush_i     = 1'b1;
        rob_ready_i = 1'b1;
        @(negedge clk);
        check("t5_flush_no_dispatch", 64'(rob_valid_o), 64'd0);
        step();
        flush_i  = 1'b0;
        valid_in = 1'b0;
        pkt_in   = '0;
        @(negedge clk);
        check("t5_post_flush_count", 64'(count_o), 64'd0);
        step();

        // ---------------- Pointer wrap with mixed classes ----------------
        cls_seq = '{C_ALU, C_LD, C_BR, C_ST, C_JMP, C_ALU, C_LD, C_BR, C_ALU, C_ST};
        rob_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bit r1;
            bit r2;
            int s2;
            r1 = k[0];
            r2 = k[1];
            s2 = (k == 4) ? 0 : 30 + k;
            p  = mk(cls_seq[k], 50 + k, k, 1 + k, r1, s2, r2);
            expect_dispatch(p, cls_seq[k], r1, (k == 4) ? 1'b1 : r2);
            if (k == 3) rob_ready_i = 1'b1;
            enq_wait(p, "t6");
        end
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
